key_event_fsm: RTL



---
 rtl/key_event_pkg.sv | 16 +
 rtl/key_event_fsm_hold_timer.sv | 46 ++++
 rtl/key_event_fsm.sv | 137 +++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared types for the key event path: FSM state encoding and event codes
// as seen by the CPU IO-read mux.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } state_e;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_LONG    = 2'd1;
  localparam logic [1:0] EV_REPEAT  = 2'd2;
  localparam logic [1:0] EV_RELEASE = 2'd3;

endpackage

// File: rtl/key_event_fsm_hold_timer.sv
// Hold timer: counts slow_clk edges while a key stays down and flags the
// LONG and REPEAT thresholds. The FSM clears it on every state entry and at
// every threshold, so it never wraps.
module hold_timer #(
  parameter int CNT_W         = 16,
  parameter int LONG_CYCLES   = 200,
  parameter int REPEAT_CYCLES = 50
) (
  input  logic slow_clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_long_o,
  output logic hit_repeat_o
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d; otherwise a latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge slow_clk or negedge reset_n) begin
    // NOTE: non-blocking assignments in clocked blocks keep register updates order-independent.
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_long_o   = (cnt_q == LONG_LAST);
  assign hit_repeat_o = (cnt_q == REPEAT_LAST);

endmodule

// File: rtl/key_event_fsm.sv
// Key event FSM: turns the debounced key level into PRESS / LONG / REPEAT /
// RELEASE events and holds each one in a one-deep valid/ack register for the
// CPU, flagging events lost while the register was still full.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 200,
  parameter int REPEAT_CYCLES = 50,
  parameter int CNT_W         = 16
) (
  input  logic       slow_clk,
  input  logic       reset_n,
  input  logic       key_in,
  input  logic       ev_ack,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic       ev_overrun,
  output logic       key_held
);

  state_e     state_q, state_d;
  logic       tmr_clr, tmr_en;
  logic       hit_long, hit_repeat;
  logic       emit;
  logic [1:0] emit_code;

  logic       ev_valid_q, ev_valid_d;
  logic [1:0] ev_code_q, ev_code_d;
  logic       ev_overrun_q, ev_overrun_d;
  logic       key_held_q;

  hold_timer #(
    .CNT_W         (CNT_W),
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_hold_timer (
    .slow_clk     (slow_clk),
    .reset_n      (reset_n),
    .clr_i        (tmr_clr),
    .en_i         (tmr_en),
    .hit_long_o   (hit_long),
    .hit_repeat_o (hit_repeat)
  );

  // Next state, timer control and event emission; release beats thresholds.
  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    emit      = 1'b0;
    emit_code = EV_PRESS;
    case (state_q)
      IDLE: begin
        if (key_in) begin
          state_d   = DOWN;
          tmr_clr   = 1'b1;
          emit      = 1'b1;
          emit_code = EV_PRESS;
        end
      end
      DOWN: begin
        if (!key_in) begin
          state_d   = IDLE;
          tmr_clr   = 1'b1;
          emit      = 1'b1;
          emit_code = EV_RELEASE;
        end else if (hit_long) begin
          state_d   = LONG;
          tmr_clr   = 1'b1;
          emit      = 1'b1;
          emit_code = EV_LONG;
        end else begin
          tmr_en = 1'b1;
        end
      end
      LONG: begin
        if (!key_in) begin
          state_d   = IDLE;
          tmr_clr   = 1'b1;
          emit      = 1'b1;
          emit_code = EV_RELEASE;
        end else if (hit_repeat) begin
          tmr_clr   = 1'b1;
          emit      = 1'b1;
          emit_code = EV_REPEAT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Event register: load when empty or being acked, else flag the overrun.
  always_comb begin
    ev_valid_d   = ev_valid_q;
    ev_code_d    = ev_code_q;
    ev_overrun_d = ev_overrun_q;
    if (ev_valid_q && ev_ack) begin
      ev_overrun_d = 1'b0;
    end
    if (emit && (!ev_valid_q || ev_ack)) begin
      ev_valid_d = 1'b1;
      ev_code_d  = emit_code;
    end else if (emit) begin
      ev_overrun_d = 1'b1;
    end else if (ev_valid_q && ev_ack) begin
      ev_valid_d = 1'b0;
    end
  end

  // State, key_held and event registers, all cleared by the async reset.
  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      key_held_q   <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= EV_PRESS;
      ev_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_held_q   <= (state_d != IDLE);
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_overrun_q <= ev_overrun_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_code    = ev_code_q;
  assign ev_overrun = ev_overrun_q;
  assign key_held   = key_held_q;

endmodule
